// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, types and sizing helpers for the CNN stream stages
// Purpose: common definitions imported by the CNN streaming blocks.
// Contents:
//   CNN_DATA_WIDTH   default pixel word width
//   upsample_factor  repeat count of the nearest-neighbour upsampler (2)
//   cnt_width        width of a counter that indexes n positions (at least 1)
//   rd_state_e       read-side state encoding of the upsampler
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 32;

  function automatic int upsample_factor();
    return 2;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_PASS0 = 2'd1,
    RD_PASS1 = 2'd2
  } rd_state_e;

endpackage

// File: rtl/cnn_upsample_row_bank.sv
// rtl/cnn_upsample_row_bank.sv - ping-pong row storage with bank-full flags
// Purpose: two IMAGE_WIDTH x DATA_WIDTH row banks, one write port, one
// asynchronous read port, and a full flag per bank.
// Ports:
//   clk, rst              clock, asynchronous active-high reset (flags only)
//   wr_req                a pixel is offered for bank wr_bank, column wr_col
//   wr_bank, wr_col       write address
//   wr_data               pixel to store
//   wr_block              offered pixel rejected: its bank is still occupied
//   clr_en, clr_bank      reader releases clr_bank this cycle
//   rd_bank, rd_col       read address
//   rd_data               combinational read data
//   full                  registered bank-full flags
//   full_fwd              full flags including a completion happening this cycle
module cnn_upsample_row_bank
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
  parameter int IMAGE_WIDTH = 4,
  localparam int CW         = cnt_width(IMAGE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic                  wr_bank,
  input  logic [CW-1:0]         wr_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_block,
  input  logic                  clr_en,
  input  logic                  clr_bank,
  input  logic                  rd_bank,
  input  logic [CW-1:0]         rd_col,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            full,
  output logic [1:0]            full_fwd
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [2][IMAGE_WIDTH];
  logic [1:0]            full_q, full_d;
  logic [1:0]            set_vec, clr_vec;
  logic                  wr_acc;

  always_comb begin
    clr_vec = 2'b00;
    if (clr_en) clr_vec[clr_bank] = 1'b1;
    // A bank being released this cycle may already take the next row.
    wr_block = wr_req && full_q[wr_bank] && !clr_vec[wr_bank];
    wr_acc   = wr_req && !wr_block;
    set_vec  = 2'b00;
    if (wr_acc && (wr_col == COL_LAST)) set_vec[wr_bank] = 1'b1;
    full_d   = (full_q & ~clr_vec) | set_vec;
    // Lets the reader chain straight into a bank completing this cycle.
    full_fwd = full_q | set_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 2'b00;
    else     full_q <= full_d;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_bank][wr_col] <= wr_data;
  end

  assign rd_data = mem_q[rd_bank][rd_col];
  assign full    = full_q;

endmodule

// File: rtl/cnn_upsample_2x_nearest.sv
// rtl/cnn_upsample_2x_nearest.sv - streaming 2x nearest-neighbour upsampler
// Purpose: takes raster pixels of IMAGE_WIDTH x IMAGE_WIDTH channels and emits
// 2*IMAGE_WIDTH x 2*IMAGE_WIDTH channels; every pixel is doubled horizontally
// and every row is emitted twice (PASS0, PASS1) from a ping-pong row buffer.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   valid_in     input pixel strobe
//   in           input pixel, raster order
//   out          upsampled pixel (registered, holds while idle)
//   valid_out    output pixel strobe (registered)
//   last_out     pulse with the final pixel of each output channel
//   overflow     sticky: a pixel arrived for a bank that was still occupied
module cnn_upsample_2x_nearest
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
  parameter int IMAGE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  valid_out,
  output logic                  last_out,
  output logic                  overflow
);

  localparam int            CW       = cnt_width(IMAGE_WIDTH);
  localparam int            DW       = cnt_width(upsample_factor());
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [DW-1:0] DUP_LAST = DW'(upsample_factor() - 1);

  rd_state_e state_q, state_d;

  logic [CW-1:0]         wr_col_q, wr_col_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  overflow_q, overflow_d;
  logic [CW-1:0]         rd_col_q, rd_col_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [DW-1:0]         dup_q, dup_d;
  logic [CW-1:0]         out_row_q, out_row_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  logic                  wr_block;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            full, full_fwd;
  logic                  active, pass_end, rd_end, nxt_bank;

  cnn_upsample_row_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMAGE_WIDTH(IMAGE_WIDTH)
  ) u_bank (
    .clk     (clk),
    .rst     (reset),
    .wr_req  (valid_in),
    .wr_bank (wr_bank_q),
    .wr_col  (wr_col_q),
    .wr_data (in),
    .wr_block(wr_block),
    .clr_en  (rd_end),
    .clr_bank(rd_bank_q),
    .rd_bank (rd_bank_q),
    .rd_col  (rd_col_q),
    .rd_data (rd_data),
    .full    (full),
    .full_fwd(full_fwd)
  );

  // The first output of a row is emitted in the same cycle IDLE sees the full
  // flag, so a pass spans 2*IMAGE_WIDTH cycles counted from that cycle.
  always_comb begin
    active   = (state_q != RD_IDLE) || full[rd_bank_q];
    pass_end = active && (rd_col_q == COL_LAST) && (dup_q == DUP_LAST);
    rd_end   = pass_end && (state_q == RD_PASS1);
    nxt_bank = ~rd_bank_q;
  end

  // Write side: counters keep advancing on a blocked pixel to hold geometry.
  always_comb begin
    wr_col_d  = wr_col_q;
    wr_bank_d = wr_bank_q;
    if (valid_in) begin
      if (wr_col_q == COL_LAST) begin
        wr_col_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_col_d = wr_col_q + CW'(1);
      end
    end
    overflow_d = overflow_q | wr_block;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE:  if (full[rd_bank_q]) state_d = RD_PASS0;
      RD_PASS0: if (pass_end) state_d = RD_PASS1;
      RD_PASS1: if (pass_end) state_d = full_fwd[nxt_bank] ? RD_PASS0 : RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    dup_d     = dup_q;
    rd_col_d  = rd_col_q;
    rd_bank_d = rd_bank_q;
    out_row_d = out_row_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    if (active) begin
      valid_d = 1'b1;
      out_d   = rd_data;
      if (dup_q == DUP_LAST) begin
        dup_d    = '0;
        rd_col_d = (rd_col_q == COL_LAST) ? '0 : rd_col_q + CW'(1);
      end else begin
        dup_d = dup_q + DW'(1);
      end
      if (rd_end) begin
        rd_bank_d = nxt_bank;
        out_row_d = out_row_q + CW'(1);
        last_d    = (out_row_q == ROW_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_col_q   <= '0;
      wr_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
      rd_col_q   <= '0;
      rd_bank_q  <= 1'b0;
      dup_q      <= '0;
      out_row_q  <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      wr_col_q   <= wr_col_d;
      wr_bank_q  <= wr_bank_d;
      overflow_q <= overflow_d;
      rd_col_q   <= rd_col_d;
      rd_bank_q  <= rd_bank_d;
      dup_q      <= dup_d;
      out_row_q  <= out_row_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign out       = out_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cnn_upsample_2x_nearest.sv
// tb/tb_cnn_upsample_2x_nearest.sv - self-checking bench for cnn_upsample_2x_nearest
module tb_cnn_upsample_2x_nearest;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] in_d;
  logic [31:0] out;
  logic        valid_out, last_out, overflow;

  always #5 clk = ~clk;

  cnn_upsample_2x_nearest #(.DATA_WIDTH(32), .IMAGE_WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .in       (in_d),
    .out      (out),
    .valid_out(valid_out),
    .last_out (last_out),
    .overflow (overflow)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct packed {
    logic [3:0][31:0] pix;
    int               gap;
    int               exp_lat;
    int               exp_cnt;
    logic             exp_ovf;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[4];
  int   total = 0;
  int   bad   = 0;
  int   src_row = 0;
  logic sb_ignore = 1'b1;
  int   cyc = 0, mon_n = 0, first_v = 0, last_v = 0, n_last = 0;
  int   last_idx[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][31:0] mk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference model: each source row appears as two output rows, each pixel
  // twice; the 4th source row of a channel carries last on its final pixel.
  task automatic push_row(input logic [3:0][31:0] p);
    exp_t e;
    for (int ps = 0; ps < 2; ps++)
      for (int c = 0; c < 4; c++)
        for (int d = 0; d < 2; d++) begin
          e.data = p[c];
          e.last = (src_row == 3) && (ps == 1) && (c == 3) && (d == 1);
          sb_q.push_back(e);
        end
    src_row = (src_row + 1) % 4;
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    valid_in = 1'b1;
    in_d     = d;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic mon_clear();
    mon_n = 0; n_last = 0; first_v = 0; last_v = 0;
    last_idx[0] = 0; last_idx[1] = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 600) begin @(negedge clk); k++; end
    chk("drain_done", sb_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (valid_out && !sb_ignore) begin
      mon_n++;
      if (mon_n == 1) first_v = cyc;
      last_v = cyc;
      if (last_out) begin
        if (n_last < 2) last_idx[n_last] = mon_n;
        n_last++;
      end
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got out=%0h with no pending expectation at %0t", out, $time);
      end else begin
        e = sb_q.pop_front();
        chk("out_data", out, e.data);
        chk("out_last", last_out, e.last);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic found;
    logic held;

    tbl[0] = '{pix: mk(32'd1, 32'd2, 32'd3, 32'd4), gap: 1, exp_lat: 2, exp_cnt: 16, exp_ovf: 1'b0};
    tbl[1] = '{pix: mk(32'd10, 32'd20, 32'd30, 32'd40), gap: 4, exp_lat: 2, exp_cnt: 16, exp_ovf: 1'b0};
    tbl[2] = '{pix: mk(32'hdeadbeef, 32'd0, 32'hffffffff, 32'd5), gap: 2, exp_lat: 2, exp_cnt: 16, exp_ovf: 1'b0};
    tbl[3] = '{pix: mk(32'd7, 32'd7, 32'd8, 32'd8), gap: 3, exp_lat: 2, exp_cnt: 16, exp_ovf: 1'b0};

    reset = 1'b1; valid_in = 1'b0; in_d = '0;
    #2;
    chk("rst_out", out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_ovf", overflow, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sb_ignore = 1'b0;

    // Single rows, each run from idle.
    for (int r = 0; r < 4; r++) begin
      mon_clear();
      push_row(tbl[r].pix);
      for (int c = 0; c < 4; c++) send(tbl[r].pix[c], (c == 3) ? 1 : tbl[r].gap);
      lat = 0; found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        @(negedge clk); lat++;
        if (valid_out) found = 1'b1;
      end
      chk("row_latency", lat, tbl[r].exp_lat);
      drain();
      chk("row_count", mon_n, tbl[r].exp_cnt);
      chk("row_contig", last_v - first_v + 1, tbl[r].exp_cnt);
      chk("row_ovf", overflow, tbl[r].exp_ovf);
    end

    // Full paced channel 0..15: 64 gap-free outputs, one last pulse.
    mon_clear();
    for (int r = 0; r < 4; r++) begin
      push_row(mk(4*r, 4*r+1, 4*r+2, 4*r+3));
      for (int c = 0; c < 4; c++) send(4*r + c, 4);
    end
    drain();
    chk("chan_count", mon_n, 64);
    chk("chan_contig", last_v - first_v + 1, 64);
    chk("chan_nlast", n_last, 1);
    chk("chan_last_pos", last_idx[0], 64);
    chk("chan_ovf", overflow, 0);

    // Two paced channels back to back.
    mon_clear();
    for (int r = 0; r < 8; r++) begin
      push_row(mk(100+4*r, 101+4*r, 102+4*r, 103+4*r));
      for (int c = 0; c < 4; c++) send(100 + 4*r + c, 4);
    end
    drain();
    chk("two_count", mon_n, 128);
    chk("two_contig", last_v - first_v + 1, 128);
    chk("two_nlast", n_last, 2);
    chk("two_last_pos0", last_idx[0], 64);
    chk("two_last_pos1", last_idx[1], 128);

    // 12 back-to-back pixels: the 9th finds bank 0 still occupied.
    sb_ignore = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      valid_in = 1'b1; in_d = i;
      @(posedge clk); #1;
      chk($sformatf("ovf_after_pix%0d", i), overflow, (i >= 9) ? 1 : 0);
    end
    valid_in = 1'b0;
    held = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (overflow !== 1'b1) held = 1'b0;
    end
    chk("ovf_sticky", held, 1);
    reset = 1'b1; #1;
    chk("ovf_cleared_by_rst", overflow, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset in the middle of PASS0, then a fresh row.
    for (int c = 0; c < 4; c++) send(5 + c, 1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (valid_out) found = 1'b1;
    end
    @(negedge clk);
    chk("pre_rst_valid", valid_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_out", out, 0);
    chk("midrst_last", last_out, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    sb_q.delete();
    src_row = 0;
    mon_clear();
    sb_ignore = 1'b0;
    push_row(mk(32'd9, 32'd8, 32'd7, 32'd6));
    for (int c = 0; c < 4; c++) send(9 - c, 1);
    drain();
    chk("post_rst_count", mon_n, 16);
    chk("post_rst_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
